seq_mult_shift_add: RTL and testbench



---
 rtl/seq_mult_shift_add_pkg.sv | 12 +
 rtl/seq_mult_shift_add_rca_nbit.sv | 24 ++
 rtl/seq_mult_shift_add.sv | 105 ++++++++++
 tb/tb_seq_mult_shift_add.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_shift_add_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

   localparam int unsigned MULT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } mult_state_t;

endpackage

// File: rtl/seq_mult_shift_add_rca_nbit.sv
// Parameterised ripple-carry adder, purely combinational.
module rca_nbit #(
   parameter int unsigned WIDTH = mult_pkg::MULT_W_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic carry;

   always_comb begin
      sum   = '0;
      carry = cin;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier: one WIDTH-bit add per clock,
// start/busy/done handshake, registered 2*WIDTH-bit product.
module seq_mult_shift_add
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   mult_state_t        state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;
   logic [WIDTH-1:0]   sel_sum;
   logic               sel_c;

   rca_nbit #(.WIDTH(WIDTH)) u_rca (
      .a   (acc_q),
      .b   (m_q),
      .cin (1'b0),
      .sum (add_sum),
      .cout(add_cout)
   );

   // The add carry C is shifted into ACC's MSB in the same cycle it is produced,
   // so it never needs to persist across a clock edge.
   assign sel_sum = q_q[0] ? add_sum : acc_q;
   assign sel_c   = q_q[0] & add_cout;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      q_d       = q_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d = {sel_c, sel_sum[WIDTH-1:1]};
            q_d   = {sel_sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               product_d = {acc_d, q_d};
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         q_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         q_q       <= q_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q == CALC);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Bench for seq_mult_shift_add: WIDTH=4 and WIDTH=8 instances checked every
// cycle against an event-timed model, plus literal expectations.
module tb_seq_mult_shift_add;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  prod4;
   logic [15:0] prod8;

   int errors = 0;
   int checks = 0;

   // model: a request occupies the unit until a completion WIDTH edges later
   int          e = 0;
   bit          chk_en = 1'b0;
   bit          m_pend [2];
   bit          m_done [2];
   int          m_due  [2];
   logic [15:0] m_val  [2];
   logic [15:0] m_prod [2];

   always #5 clk = ~clk;

   seq_mult_shift_add #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .product(prod4)
   );

   seq_mult_shift_add #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, e);
      end
   endtask

   always @(posedge clk) begin
      e++;
      if (!rst_n) chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bit          s, was;
         int          w;
         logic [15:0] pa, pb;
         w  = (i == 0) ? 4 : 8;
         s  = (i == 0) ? start4 : start8;
         pa = (i == 0) ? {12'h0, a4} : {8'h0, a8};
         pb = (i == 0) ? {12'h0, b4} : {8'h0, b8};
         if (!rst_n) begin
            m_pend[i] = 1'b0;
            m_done[i] = 1'b0;
            m_prod[i] = '0;
         end else begin
            was       = m_pend[i];
            m_done[i] = 1'b0;
            if (was && e == m_due[i]) begin
               m_prod[i] = m_val[i];
               m_done[i] = 1'b1;
               m_pend[i] = 1'b0;
            end
            if (s && !was) begin
               m_pend[i] = 1'b1;
               m_due[i]  = e + w;
               m_val[i]  = pa * pb;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy4", 32'(busy4), 32'(m_pend[0]));
         chk("done4", 32'(done4), 32'(m_done[0]));
         chk("prod4", 32'(prod4), 32'(m_prod[0][7:0]));
         chk("busy8", 32'(busy8), 32'(m_pend[1]));
         chk("done8", 32'(done8), 32'(m_done[1]));
         chk("prod8", 32'(prod8), 32'(m_prod[1]));
      end
   end

   task automatic launch4(input logic [3:0] x, input logic [3:0] y);
      start4 = 1'b1; a4 = x; b4 = y;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
   endtask

   task automatic go4(input logic [3:0] x, input logic [3:0] y);
      @(negedge clk);
      launch4(x, y);
   endtask

   task automatic go8(input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      start8 = 1'b1; a8 = x; b8 = y;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
   endtask

   task automatic wait_done4(input string nm, input logic [7:0] exp, input int lat);
      int n = 0;
      while (!done4 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!done4) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done expected done within 30 cycles", nm);
      end else begin
         chk({nm, "_prod"}, 32'(prod4), 32'(exp));
         chk({nm, "_lat"}, n, lat);
      end
   endtask

   task automatic wait_done8(input string nm, input logic [15:0] exp, input int lat);
      int n = 0;
      while (!done8 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!done8) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done expected done within 30 cycles", nm);
      end else begin
         chk({nm, "_prod"}, 32'(prod8), 32'(exp));
         chk({nm, "_lat"}, n, lat);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int e_first;
      rst_n = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_done", 32'(done4), 32'd0);
      chk("rst_prod", 32'(prod4), 32'd0);
      rst_n = 1'b1;

      go4(4'd9, 4'd6);
      wait_done4("9x6", 8'h36, 4);
      go4(4'd15, 4'd15);
      wait_done4("15x15", 8'hE1, 4);
      go4(4'd0, 4'd13);
      wait_done4("0x13", 8'h00, 4);

      // start held high with changing operands while busy; only 3*5 counts
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd3;  b4 = 4'd5;
      @(negedge clk); a4 = 4'd6;  b4 = 4'd9;
      @(negedge clk); a4 = 4'd10; b4 = 4'd11;
      @(negedge clk); a4 = 4'd4;  b4 = 4'd4;
      @(negedge clk); start4 = 1'b0;
      wait_done4("ignore_start", 8'd15, 1);

      go4(4'd7, 4'd7);
      wait_done4("b2b_first", 8'd49, 4);
      e_first = e;
      launch4(4'd2, 4'd11);
      wait_done4("b2b_second", 8'd22, 4);
      chk("b2b_gap", e - e_first, 5);

      go4(4'd12, 4'd12);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_done", 32'(done4), 32'd0);
      chk("abort_prod", 32'(prod4), 32'd0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      go4(4'd12, 4'd12);
      wait_done4("after_abort", 8'd144, 4);

      go8(8'd255, 8'd255);
      wait_done8("w8_255x255", 16'hFE01, 8);
      go8(8'd200, 8'd3);
      wait_done8("w8_200x3", 16'd600, 8);

      for (int i = 0; i < 256; i++) begin
         logic [3:0] x, y;
         x = 4'(i >> 4);
         y = 4'(i & 15);
         go4(x, y);
         wait_done4("sweep", 8'((i >> 4) * (i & 15)), 4);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
